// File: rtl/spi_flash_seq.sv
// SPI flash command sequencer: sends opcode, optional 24-bit address, then
// reads cmd_len bytes through a single-byte exchange engine.
`timescale 1ns/1ps
module spi_flash_seq #(
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_GAP   = 4,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_opcode,
  input  logic        cmd_addr_en,
  input  logic [23:0] cmd_addr,
  input  logic [15:0] cmd_len,
  input  logic        abort,
  output logic        spi_cs,
  output logic        byte_start,
  output logic [7:0]  byte_tx,
  input  logic        byte_done,
  input  logic [7:0]  byte_rx,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  input  logic        rd_ready,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_OP, S_ADDR, S_READ, S_HOLD, S_GAP
  } state_t;

  localparam logic [3:0]  SETUP_LAST = 4'(CS_SETUP - 1);
  localparam logic [3:0]  GAP_LAST   = 4'(CS_GAP - 1);
  localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT - 1);

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [1:0]  addr_idx, addr_idx_n;
  logic [15:0] tmo, tmo_n;
  logic [15:0] remaining, remaining_n;
  logic [7:0]  opcode_q, opcode_n;
  logic        addr_en_q, addr_en_n;
  logic [23:0] addr_q, addr_n;
  logic        spi_cs_n, byte_start_n, rd_valid_n, done_n, error_n;
  logic [7:0]  byte_tx_n, rd_data_n;
  logic        outstanding, hdr_end, finish;

  // A byte is in flight exactly while in OP, ADDR or READ.
  assign outstanding = (state == S_OP) || (state == S_ADDR) || (state == S_READ);
  assign cmd_ready   = (state == S_IDLE);
  assign busy        = (state != S_IDLE);

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    addr_idx_n   = addr_idx;
    tmo_n        = tmo;
    remaining_n  = remaining;
    opcode_n     = opcode_q;
    addr_en_n    = addr_en_q;
    addr_n       = addr_q;
    spi_cs_n     = spi_cs;
    byte_start_n = 1'b0;
    byte_tx_n    = byte_tx;
    rd_valid_n   = rd_valid;
    rd_data_n    = rd_data;
    done_n       = 1'b0;
    error_n      = error;
    hdr_end      = 1'b0;
    finish       = 1'b0;

    // Abort takes priority over everything, including a coincident byte_done.
    if (abort && state != S_IDLE) begin
      state_n    = S_GAP;
      cnt_n      = '0;
      spi_cs_n   = 1'b1;
      rd_valid_n = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            opcode_n    = cmd_opcode;
            addr_en_n   = cmd_addr_en;
            addr_n      = cmd_addr;
            remaining_n = cmd_len;
            error_n     = 1'b0;
            spi_cs_n    = 1'b0;
            cnt_n       = '0;
            state_n     = S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == SETUP_LAST) begin
            state_n      = S_OP;
            byte_start_n = 1'b1;
            byte_tx_n    = opcode_q;
            tmo_n        = '0;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
        S_OP: begin
          if (byte_done) begin
            if (addr_en_q) begin
              state_n      = S_ADDR;
              addr_idx_n   = '0;
              byte_start_n = 1'b1;
              byte_tx_n    = addr_q[23:16];
              tmo_n        = '0;
            end else begin
              hdr_end = 1'b1;
            end
          end
        end
        S_ADDR: begin
          if (byte_done) begin
            if (addr_idx == 2'd2) begin
              hdr_end = 1'b1;
            end else begin
              addr_idx_n   = addr_idx + 2'd1;
              byte_start_n = 1'b1;
              byte_tx_n    = (addr_idx == 2'd0) ? addr_q[15:8] : addr_q[7:0];
              tmo_n        = '0;
            end
          end
        end
        S_READ: begin
          if (byte_done) begin
            rd_data_n   = byte_rx;
            rd_valid_n  = 1'b1;
            remaining_n = remaining - 16'd1;
            state_n     = S_HOLD;
          end
        end
        S_HOLD: begin
          if (rd_ready) begin
            rd_valid_n = 1'b0;
            if (remaining == '0) begin
              finish = 1'b1;
            end else begin
              state_n      = S_READ;
              byte_start_n = 1'b1;
              byte_tx_n    = '0;
              tmo_n        = '0;
            end
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) state_n = S_IDLE;
          else                 cnt_n   = cnt + 4'd1;
        end
        default: state_n = S_IDLE;
      endcase

      if (hdr_end) begin
        if (remaining != '0) begin
          state_n      = S_READ;
          byte_start_n = 1'b1;
          byte_tx_n    = '0;
          tmo_n        = '0;
        end else begin
          finish = 1'b1;
        end
      end

      if (finish) begin
        state_n  = S_GAP;
        cnt_n    = '0;
        spi_cs_n = 1'b1;
        done_n   = 1'b1;
      end

      if (outstanding && !byte_done) begin
        if (tmo == TMO_LAST) begin
          error_n    = 1'b1;
          rd_valid_n = 1'b0;
          state_n    = S_GAP;
          cnt_n      = '0;
          spi_cs_n   = 1'b1;
        end else begin
          tmo_n = tmo + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      addr_idx   <= '0;
      tmo        <= '0;
      remaining  <= '0;
      opcode_q   <= '0;
      addr_en_q  <= 1'b0;
      addr_q     <= '0;
      spi_cs     <= 1'b1;
      byte_start <= 1'b0;
      byte_tx    <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      addr_idx   <= addr_idx_n;
      tmo        <= tmo_n;
      remaining  <= remaining_n;
      opcode_q   <= opcode_n;
      addr_en_q  <= addr_en_n;
      addr_q     <= addr_n;
      spi_cs     <= spi_cs_n;
      byte_start <= byte_start_n;
      byte_tx    <= byte_tx_n;
      rd_valid   <= rd_valid_n;
      rd_data    <= rd_data_n;
      done       <= done_n;
      error      <= error_n;
    end
  end

endmodule
